// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the IEEE 1149.1 TAP controller.
// Holds the 16-state encoding, default opcodes and the IR capture pattern.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TLR,
        RTI,
        SEL_DR,
        CAP_DR,
        SH_DR,
        EX1_DR,
        PAU_DR,
        EX2_DR,
        UPD_DR,
        SEL_IR,
        CAP_IR,
        SH_IR,
        EX1_IR,
        PAU_IR,
        EX2_IR,
        UPD_IR
    } tap_state_t;

    localparam logic [31:0] DEF_IDCODE_VALUE = 32'h149511c3;
    localparam logic [3:0]  OPC_IDCODE       = 4'b0010;
    localparam logic [3:0]  OPC_DEBUG        = 4'b1000;
    localparam logic [3:0]  OPC_BYPASS       = 4'b1111;

    // The two LSBs of every Capture-IR value; upper bits are zero-filled.
    localparam logic [1:0]  IR_CAPTURE_LSBS  = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine advanced by TMS on the rising TCK edge.
// Exposes the current and next state plus the DR state decodes.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_rst,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_next_state,
    output logic       o_test_logic_reset,
    output logic       o_run_test_idle,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_pause_dr,
    output logic       o_update_dr
);

    tap_state_t r_state;
    tap_state_t w_next_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_tck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TLR:     w_next_state = i_tms ? TLR    : RTI;
            RTI:     w_next_state = i_tms ? SEL_DR : RTI;
            SEL_DR:  w_next_state = i_tms ? SEL_IR : CAP_DR;
            CAP_DR:  w_next_state = i_tms ? EX1_DR : SH_DR;
            SH_DR:   w_next_state = i_tms ? EX1_DR : SH_DR;
            EX1_DR:  w_next_state = i_tms ? UPD_DR : PAU_DR;
            PAU_DR:  w_next_state = i_tms ? EX2_DR : PAU_DR;
            EX2_DR:  w_next_state = i_tms ? UPD_DR : SH_DR;
            UPD_DR:  w_next_state = i_tms ? SEL_DR : RTI;
            SEL_IR:  w_next_state = i_tms ? TLR    : CAP_IR;
            CAP_IR:  w_next_state = i_tms ? EX1_IR : SH_IR;
            SH_IR:   w_next_state = i_tms ? EX1_IR : SH_IR;
            EX1_IR:  w_next_state = i_tms ? UPD_IR : PAU_IR;
            PAU_IR:  w_next_state = i_tms ? EX2_IR : PAU_IR;
            EX2_IR:  w_next_state = i_tms ? UPD_IR : SH_IR;
            UPD_IR:  w_next_state = i_tms ? SEL_DR : RTI;
            default: w_next_state = TLR;
        endcase
    end

    assign o_state            = r_state;
    assign o_next_state       = w_next_state;
    assign o_test_logic_reset = (r_state == TLR);
    assign o_run_test_idle    = (r_state == RTI);
    assign o_capture_dr       = (r_state == CAP_DR);
    assign o_shift_dr         = (r_state == SH_DR);
    assign o_pause_dr         = (r_state == PAU_DR);
    assign o_update_dr        = (r_state == UPD_DR);

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: IR, IDCODE and BYPASS data registers, and a
// debug-DR select, with TDO launched on the falling TCK edge.
module jtag_tap_controller
    import jtag_tap_pkg::*;
#(
    parameter int                     IR_LENGTH    = 4,
    parameter logic [31:0]            IDCODE_VALUE = DEF_IDCODE_VALUE,
    parameter logic [IR_LENGTH-1:0]   IDCODE_INSTR = IR_LENGTH'(OPC_IDCODE),
    parameter logic [IR_LENGTH-1:0]   DEBUG_INSTR  = IR_LENGTH'(OPC_DEBUG),
    parameter logic [IR_LENGTH-1:0]   BYPASS_INSTR = IR_LENGTH'(OPC_BYPASS)
) (
    input  logic tck_i,
    input  logic rst_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic debug_select_o,
    output logic test_logic_reset_o,
    output logic run_test_idle_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o
);

    localparam logic [IR_LENGTH-1:0] IR_CAPTURE = {{(IR_LENGTH-2){1'b0}}, IR_CAPTURE_LSBS};

    tap_state_t w_state;
    tap_state_t w_next_state;

    logic [IR_LENGTH-1:0] r_ir_shift;
    logic [IR_LENGTH-1:0] r_ir_latched;
    logic [31:0]          r_idcode;
    logic                 r_bypass;
    logic                 r_tdo;
    logic                 r_tdo_oe;

    logic w_sel_idcode;
    logic w_sel_debug;
    logic w_shifting;
    logic w_tdo;

    jtag_tap_fsm u_fsm (
        .i_tck              (tck_i),
        .i_rst              (rst_i),
        .i_tms              (tms_i),
        .o_state            (w_state),
        .o_next_state       (w_next_state),
        .o_test_logic_reset (test_logic_reset_o),
        .o_run_test_idle    (run_test_idle_o),
        .o_capture_dr       (capture_dr_o),
        .o_shift_dr         (shift_dr_o),
        .o_pause_dr         (pause_dr_o),
        .o_update_dr        (update_dr_o)
    );

    // Any opcode that is neither IDCODE nor DEBUG (BYPASS_INSTR included) selects BYPASS.
    assign w_sel_idcode = (r_ir_latched == IDCODE_INSTR);
    assign w_sel_debug  = (r_ir_latched == DEBUG_INSTR);
    assign w_shifting   = (w_state == SH_IR) || (w_state == SH_DR);

    always_ff @(posedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_ir_shift   <= '0;
            r_ir_latched <= IDCODE_INSTR;
            r_idcode     <= '0;
            r_bypass     <= 1'b0;
        end else begin
            case (w_state)
                CAP_IR: r_ir_shift <= IR_CAPTURE;
                SH_IR:  r_ir_shift <= {tdi_i, r_ir_shift[IR_LENGTH-1:1]};
                CAP_DR: begin
                    if (w_sel_idcode)      r_idcode <= IDCODE_VALUE;
                    else if (!w_sel_debug) r_bypass <= 1'b0;
                end
                SH_DR: begin
                    if (w_sel_idcode)      r_idcode <= {tdi_i, r_idcode[31:1]};
                    else if (!w_sel_debug) r_bypass <= tdi_i;
                end
                default: ;
            endcase

            if (w_next_state == TLR) begin
                r_ir_latched <= IDCODE_INSTR;
            end else if (w_state == UPD_IR) begin
                r_ir_latched <= r_ir_shift;
            end
        end
    end

    always_comb begin
        w_tdo = 1'b0;
        case (w_state)
            SH_IR: w_tdo = r_ir_shift[0];
            SH_DR: begin
                if (w_sel_idcode)     w_tdo = r_idcode[0];
                else if (w_sel_debug) w_tdo = debug_tdo_i;
                else                  w_tdo = r_bypass;
            end
            default: w_tdo = 1'b0;
        endcase
    end

    // Launch on the falling edge so the pin is stable around the next rising edge.
    always_ff @(negedge tck_i or posedge rst_i) begin
        if (rst_i) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo;
            r_tdo_oe <= w_shifting;
        end
    end

    assign tdo_o          = r_tdo;
    assign tdo_oe_o       = r_tdo_oe;
    assign debug_select_o = w_sel_debug;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: an FSM walk table followed by
// hand-written IR/DR scan sequences and reset corner cases.
module tb_jtag_tap_controller;

    logic tck_i = 1'b0;
    logic rst_i;
    logic tms_i;
    logic tdi_i;
    logic tdo_o;
    logic tdo_oe_o;
    logic debug_tdo_i;
    logic debug_select_o;
    logic test_logic_reset_o;
    logic run_test_idle_o;
    logic capture_dr_o;
    logic shift_dr_o;
    logic pause_dr_o;
    logic update_dr_o;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected outputs packed as {tlr, rti, cap_dr, sh_dr, pau_dr, upd_dr, tdo_oe, tdo}
    typedef struct packed {
        logic       tms;
        logic       tdi;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[24];

    jtag_tap_controller dut (
        .tck_i              (tck_i),
        .rst_i              (rst_i),
        .tms_i              (tms_i),
        .tdi_i              (tdi_i),
        .tdo_o              (tdo_o),
        .tdo_oe_o           (tdo_oe_o),
        .debug_tdo_i        (debug_tdo_i),
        .debug_select_o     (debug_select_o),
        .test_logic_reset_o (test_logic_reset_o),
        .run_test_idle_o    (run_test_idle_o),
        .capture_dr_o       (capture_dr_o),
        .shift_dr_o         (shift_dr_o),
        .pause_dr_o         (pause_dr_o),
        .update_dr_o        (update_dr_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge,
    // so both the new state and the freshly launched TDO are visible.
    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        @(negedge tck_i);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {test_logic_reset_o, run_test_idle_o, capture_dr_o, shift_dr_o,
                pause_dr_o, update_dr_o, tdo_oe_o, tdo_o};
    endfunction

    // Full scan from RTI back to RTI. dbg is presented on debug_tdo_i one bit per shift cycle.
    task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                        input logic [31:0] dbg, output logic [31:0] dout, output int oe_bad);
        dout   = '0;
        oe_bad = 0;
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        debug_tdo_i = dbg[0];
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            if (tdo_oe_o !== 1'b1) oe_bad++;
            if (i + 1 < n) debug_tdo_i = dbg[i+1];
            step(i == n - 1, din[i]);
        end
        if (tdo_oe_o !== 1'b0) oe_bad++;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        debug_tdo_i = 1'b0;
    endtask

    initial begin
        logic [31:0] dout;
        int          oe_bad;

        vecs = '{
            '{1'b0, 1'b0, 8'b0100_0000},  // RTI
            '{1'b1, 1'b0, 8'b0000_0000},  // SEL_DR
            '{1'b0, 1'b0, 8'b0010_0000},  // CAP_DR
            '{1'b0, 1'b0, 8'b0001_0011},  // SH_DR, idcode bit0
            '{1'b1, 1'b0, 8'b0000_0000},  // EX1_DR
            '{1'b0, 1'b0, 8'b0000_1000},  // PAU_DR
            '{1'b0, 1'b0, 8'b0000_1000},  // PAU_DR
            '{1'b1, 1'b0, 8'b0000_0000},  // EX2_DR
            '{1'b0, 1'b0, 8'b0001_0011},  // SH_DR, idcode bit1
            '{1'b1, 1'b0, 8'b0000_0000},  // EX1_DR
            '{1'b1, 1'b0, 8'b0000_0100},  // UPD_DR
            '{1'b1, 1'b0, 8'b0000_0000},  // SEL_DR
            '{1'b1, 1'b0, 8'b0000_0000},  // SEL_IR
            '{1'b0, 1'b0, 8'b0000_0000},  // CAP_IR
            '{1'b0, 1'b0, 8'b0000_0011},  // SH_IR, capture LSB
            '{1'b1, 1'b0, 8'b0000_0000},  // EX1_IR
            '{1'b0, 1'b0, 8'b0000_0000},  // PAU_IR
            '{1'b1, 1'b0, 8'b0000_0000},  // EX2_IR
            '{1'b1, 1'b0, 8'b0000_0000},  // UPD_IR
            '{1'b0, 1'b0, 8'b0100_0000},  // RTI
            '{1'b1, 1'b0, 8'b0000_0000},  // SEL_DR
            '{1'b1, 1'b0, 8'b0000_0000},  // SEL_IR
            '{1'b1, 1'b0, 8'b1000_0000},  // TLR
            '{1'b1, 1'b0, 8'b1000_0000}   // TLR holds
        };

        rst_i       = 1'b1;
        tms_i       = 1'b1;
        tdi_i       = 1'b0;
        debug_tdo_i = 1'b0;
        repeat (2) @(negedge tck_i);
        #1;
        check("reset_outputs", {23'd0, outs(), debug_select_o}, {23'd0, 8'b1000_0000, 1'b0});
        rst_i = 1'b0;

        repeat (5) step(1'b1, 1'b0);
        check("five_tms_tlr", 32'(test_logic_reset_o), 32'd1);
        step(1'b0, 1'b0);
        check("rti_after_tlr", {29'd0, run_test_idle_o, debug_select_o, tdo_oe_o}, {29'd0, 3'b100});

        repeat (5) step(1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].tms, vecs[i].tdi);
            check($sformatf("walk_%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        step(1'b0, 1'b0);

        scan(1'b0, 32, 32'h0, 32'h0, dout, oe_bad);
        check("idcode_read", dout, 32'h149511c3);
        check("idcode_oe", 32'(oe_bad), 32'd0);

        scan(1'b1, 4, 32'hF, 32'h0, dout, oe_bad);
        check("ir_capture_bypass", dout, 32'h1);
        check("ir_oe", 32'(oe_bad), 32'd0);
        scan(1'b0, 8, 32'hA5, 32'h0, dout, oe_bad);
        check("bypass_a5", dout, 32'h4A);

        scan(1'b1, 4, 32'h1, 32'h0, dout, oe_bad);
        check("undef_opcode_dbgsel", 32'(debug_select_o), 32'd0);
        scan(1'b0, 8, 32'h3C, 32'h0, dout, oe_bad);
        check("undef_opcode_bypass", dout, 32'h78);

        scan(1'b1, 4, 32'h8, 32'h0, dout, oe_bad);
        check("debug_select_set", 32'(debug_select_o), 32'd1);
        debug_tdo_i = 1'b1;
        #1;
        check("debug_tdo_idle", 32'(tdo_o), 32'd0);
        debug_tdo_i = 1'b0;
        scan(1'b0, 8, 32'h0, 32'h6C, dout, oe_bad);
        check("debug_mirror", dout, 32'h6C);
        check("debug_oe", 32'(oe_bad), 32'd0);

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("debug_before_tlr", 32'(debug_select_o), 32'd1);
        step(1'b1, 1'b0);
        check("debug_tlr_clear", {30'd0, test_logic_reset_o, debug_select_o}, {30'd0, 2'b10});
        step(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, 32'h0, dout, oe_bad);
        check("idcode_after_tlr", dout, 32'h149511c3);

        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        check("mid_scan_oe", {30'd0, shift_dr_o, tdo_oe_o}, {30'd0, 2'b11});
        rst_i = 1'b1;
        #1;
        check("mid_scan_reset", 32'(outs()), 32'(8'b1000_0000));
        @(negedge tck_i);
        #1;
        rst_i = 1'b0;
        step(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, 32'h0, dout, oe_bad);
        check("idcode_after_rst", dout, 32'h149511c3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
